// File: rtl/tdm_channel_scanner.sv
// Channel sequencer and frame collector for the 8-channel mux/demux transmission stage.
// Steps the select lines through channels 0..7 and assembles one sample per channel into a frame.
module tdm_channel_scanner #(
  parameter int unsigned DWELL = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iStop,
  input  logic [7:0] iDemux,
  output logic       oA,
  output logic       oB,
  output logic       oC,
  output logic [2:0] oChannel,
  output logic       oBusy,
  output logic [7:0] oFrame,
  output logic       oValid,
  output logic [1:0] oState
);

  // Handshake: iStart is a level request honoured only in IDLE (iStop wins if both are high);
  // oValid is a single-cycle strobe with no backpressure, oFrame holds until the next frame.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [1:0] state;
  logic [2:0] channel;
  logic [7:0] dwellCnt;
  logic [7:0] shadow;
  logic [7:0] frame;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= IDLE;
      channel  <= 3'd0;
      dwellCnt <= 8'd0;
      shadow   <= 8'd0;
      frame    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          channel  <= 3'd0;
          dwellCnt <= 8'd0;
          if (iStart && !iStop) begin
            state  <= SCAN;
            shadow <= 8'd0;
          end
        end
        SCAN: begin
          // An abort on the same edge as a sample discards that sample.
          if (iStop) begin
            state    <= IDLE;
            channel  <= 3'd0;
            dwellCnt <= 8'd0;
          end else if (dwellCnt == DWELL_LAST) begin
            dwellCnt        <= 8'd0;
            shadow[channel] <= iDemux[channel];
            if (channel == 3'd7) begin
              state <= DONE;
              frame <= {iDemux[7], shadow[6:0]};
            end else begin
              channel <= channel + 3'd1;
            end
          end else begin
            dwellCnt <= dwellCnt + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          channel  <= 3'd0;
          dwellCnt <= 8'd0;
        end
        default: begin
          state    <= IDLE;
          channel  <= 3'd0;
          dwellCnt <= 8'd0;
        end
      endcase
    end
  end

  assign oA       = channel[2];
  assign oB       = channel[1];
  assign oC       = channel[0];
  assign oChannel = channel;
  assign oBusy    = (state == SCAN);
  assign oValid   = (state == DONE);
  assign oFrame   = frame;
  assign oState   = state;

endmodule

// File: tb/tb_tdm_channel_scanner.sv
// Directed bench for tdm_channel_scanner: a DWELL=4 instance for most sequences and a
// DWELL=1 instance for back-to-back frames, each driven by a combinational mux/demux stage model.
module tb_tdm_channel_scanner;

  localparam int DW = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (DWELL=4)
  logic       rstN, start, stop;
  logic [7:0] stageData, demux;
  logic       a, b, c, busy, valid;
  logic [2:0] ch;
  logic [7:0] frame;
  logic [1:0] state;

  // DUT B (DWELL=1)
  logic       bRstN, bStart, bStop;
  logic [7:0] bData, bDemux;
  logic       bA, bB, bC, bBusy, bValid;
  logic [2:0] bCh;
  logic [7:0] bFrame;
  logic [1:0] bState;

  // Transmission stage: only the selected channel's data bit appears on the demux output.
  assign demux  = stageData & (8'h01 << ch);
  assign bDemux = bData & (8'h01 << bCh);

  tdm_channel_scanner #(.DWELL(DW)) dutA (
    .iClk(clk), .iRst_n(rstN), .iStart(start), .iStop(stop), .iDemux(demux),
    .oA(a), .oB(b), .oC(c), .oChannel(ch), .oBusy(busy), .oFrame(frame),
    .oValid(valid), .oState(state)
  );

  tdm_channel_scanner #(.DWELL(1)) dutB (
    .iClk(clk), .iRst_n(bRstN), .iStart(bStart), .iStop(bStop), .iDemux(bDemux),
    .oA(bA), .oB(bB), .oC(bC), .oChannel(bCh), .oBusy(bBusy), .oFrame(bFrame),
    .oValid(bValid), .oState(bState)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    logic [7:0] nd;
    int         changeCh;
    int         restartAt;
    logic [7:0] expF;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one full frame on DUT A, optional data change at a channel and start re-pulse
  task automatic runFrame(input logic [7:0] d, input logic [7:0] nd, input int changeCh,
                          input int restartAt, input logic [7:0] expF);
    int cyc;
    int selErr;
    logic [7:0] got;
    selErr    = 0;
    stageData = d;
    start     = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    exp_q.push_back(expF);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    while (!valid && cyc < 200) begin
      if (busy) begin
        if (ch !== 3'((cyc - 1) / DW) || {a, b, c} !== ch) selErr++;
      end
      if (changeCh < 8 && ch == changeCh[2:0]) stageData = nd;
      start = (cyc == restartAt);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("select_sequence_errs", selErr, 0);
    check("valid_latency", cyc, 8 * DW + 1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    got = frame;
    check("frame", {24'd0, got}, {24'd0, exp_q.pop_front()});
    tick();
    check("valid_one_cycle", {31'd0, valid}, 32'd0);
    check("idle_after_done", {30'd0, state}, 32'd0);
    check("frame_held", {24'd0, frame}, {24'd0, expF});
  endtask

  initial begin
    int vcount;
    int nValid;
    int expCyc[4];

    vecs[0] = '{8'hA5, 8'hA5, 8, 0,  8'hA5};
    vecs[1] = '{8'h3C, 8'h3C, 8, 0,  8'h3C};
    vecs[2] = '{8'h00, 8'hFF, 3, 0,  8'hF8};
    vecs[3] = '{8'h66, 8'h66, 8, 15, 8'h66};
    vecs[4] = '{8'h81, 8'h81, 8, 0,  8'h81};
    expCyc  = '{9, 19, 29, 39};

    rstN = 1'b0; start = 1'b0; stop = 1'b0; stageData = 8'h00;
    bRstN = 1'b0; bStart = 1'b0; bStop = 1'b0; bData = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_selects", {29'd0, a, b, c}, 32'd0);
    check("rst_channel", {29'd0, ch}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame", {24'd0, frame}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    rstN  = 1'b1;
    bRstN = 1'b1;
    tick();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle_state", {30'd0, state}, 32'd0);
    check("start_stop_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    check("start_stop_idle_state2", {30'd0, state}, 32'd0);

    // table-driven frames
    for (int i = 0; i < 5; i++)
      runFrame(vecs[i].d, vecs[i].nd, vecs[i].changeCh, vecs[i].restartAt, vecs[i].expF);

    // stop on cycle 10 of SCAN
    runFrame(8'hA5, 8'hA5, 8, 0, 8'hA5);
    stageData = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_state", {30'd0, state}, 32'd0);
    check("stop_channel", {29'd0, ch}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_valid", {31'd0, valid}, 32'd0);
    nValid = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid) nValid++;
      tick();
    end
    check("stop_no_valid", nValid, 0);
    check("stop_frame_kept", {24'd0, frame}, 32'h0000_00A5);

    // async reset on cycle 20 of SCAN
    stageData = 8'h0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    check("async_rst_selects", {29'd0, a, b, c}, 32'd0);
    check("async_rst_channel", {29'd0, ch}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_frame", {24'd0, frame}, 32'd0);
    check("async_rst_valid", {31'd0, valid}, 32'd0);
    tick();
    rstN = 1'b1;
    tick();
    runFrame(8'h0F, 8'h0F, 8, 0, 8'h0F);

    // DWELL=1 back-to-back with start held high, including through DONE
    bData  = 8'h3C;
    bStart = 1'b1;
    vcount = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (bValid) begin
        if (vcount < 4) check("b_valid_cycle", cyc, expCyc[vcount]);
        check("b_frame", {24'd0, bFrame}, 32'h0000_003C);
        check("b_busy_in_done", {31'd0, bBusy}, 32'd0);
        vcount++;
      end
    end
    bStart = 1'b0;
    check("b_valid_count", vcount, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
